mips_rtype_mc: RTL and testbench



---
 rtl/mips_rtype_mc.sv | 228 ++++++++++++++++++++++
 tb/tb_mips_rtype_mc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_rtype_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_rtype_mc : multi-cycle R-type core with internal preloadable regfile |
// | Optional feature macro: MIPS_OVF_TRAP_EN (signed add/sub overflow trap)   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mips_rtype_mc #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              ld_en,
  input  logic [4:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              illegal,
  output logic              ovf
);

  localparam int AW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam int SW = $clog2(DATA_W);
  localparam logic [6:0] C_DW = 7'(DATA_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEC  = 2'd1;
  localparam logic [1:0] S_EXE  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  logic [1:0]        state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d;
  logic [DATA_W-1:0] rt_val_q, rt_val_d;
  logic [DATA_W-1:0] exe_res_q, exe_res_d;
  logic              exe_ill_q, exe_ill_d;
  logic              exe_ovf_q, exe_ovf_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              illegal_q, illegal_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rf_q [REG_CNT];
  logic [DATA_W-1:0] rf_d [REG_CNT];

  logic [AW-1:0]     rs_idx, rt_idx, rd_idx, ld_idx;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [SW-1:0]     vamt;
  logic              shamt_big;
  logic              wb_en;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ill;
  logic              alu_ovf;
  logic [DATA_W-1:0] sum, diff;

  assign rs_idx    = instr_q[21 +: AW];
  assign rt_idx    = instr_q[16 +: AW];
  assign rd_idx    = instr_q[11 +: AW];
  assign ld_idx    = ld_addr[AW-1:0];
  assign shamt     = instr_q[10:6];
  assign funct     = instr_q[5:0];
  assign vamt      = rs_val_q[SW-1:0];
  assign shamt_big = ({2'b00, shamt} >= C_DW);
  assign sum       = rs_val_q + rt_val_q;
  assign diff      = rs_val_q - rt_val_q;
  assign wb_en     = !exe_ill_q && !exe_ovf_q && (rd_idx != '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_DEC;
      S_DEC:   state_d = S_EXE;
      S_EXE:   state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    done        = done_q;
    result      = result_q;
    illegal     = illegal_q;
    ovf         = ovf_q;
  end

  // Execute: shifts take rt as the operand, variable shifts use rs as amount
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    alu_ovf = 1'b0;
    if (instr_q[31:26] != 6'b000000) begin
      alu_ill = 1'b1;
    end else begin
      case (funct)
        F_ADD: begin
          alu_res = sum;
`ifdef MIPS_OVF_TRAP_EN
          alu_ovf = (rs_val_q[DATA_W-1] == rt_val_q[DATA_W-1]) &&
                    (sum[DATA_W-1] != rs_val_q[DATA_W-1]);
`endif
        end
        F_SUB: begin
          alu_res = diff;
`ifdef MIPS_OVF_TRAP_EN
          alu_ovf = (rs_val_q[DATA_W-1] != rt_val_q[DATA_W-1]) &&
                    (diff[DATA_W-1] != rs_val_q[DATA_W-1]);
`endif
        end
        F_ADDU: alu_res = sum;
        F_SUBU: alu_res = diff;
        F_AND:  alu_res = rs_val_q & rt_val_q;
        F_OR:   alu_res = rs_val_q | rt_val_q;
        F_XOR:  alu_res = rs_val_q ^ rt_val_q;
        F_NOR:  alu_res = ~(rs_val_q | rt_val_q);
        F_SLT:  alu_res[0] = ($signed(rs_val_q) < $signed(rt_val_q));
        F_SLTU: alu_res[0] = (rs_val_q < rt_val_q);
        F_SLL:  alu_res = shamt_big ? '0 : (rt_val_q << shamt);
        F_SRL:  alu_res = shamt_big ? '0 : (rt_val_q >> shamt);
        F_SRA:  alu_res = shamt_big ? {DATA_W{rt_val_q[DATA_W-1]}}
                                    : DATA_W'($signed(rt_val_q) >>> shamt);
        F_SLLV: alu_res = rt_val_q << vamt;
        F_SRLV: alu_res = rt_val_q >> vamt;
        F_SRAV: alu_res = DATA_W'($signed(rt_val_q) >>> vamt);
        default: alu_ill = 1'b1;
      endcase
    end
  end

  // Pipeline latches and registered outputs
  always_comb begin
    instr_d   = instr_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    exe_res_d = exe_res_q;
    exe_ill_d = exe_ill_q;
    exe_ovf_d = exe_ovf_q;
    done_d    = 1'b0;
    result_d  = result_q;
    illegal_d = illegal_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: if (instr_valid) instr_d = instr;
      S_DEC: begin
        rs_val_d = rf_q[rs_idx];
        rt_val_d = rf_q[rt_idx];
      end
      S_EXE: begin
        exe_res_d = alu_res;
        exe_ill_d = alu_ill;
        exe_ovf_d = alu_ovf;
      end
      S_WB: begin
        done_d    = 1'b1;
        result_d  = exe_res_q;
        illegal_d = exe_ill_q;
        ovf_d     = exe_ovf_q;
      end
      default: ;
    endcase
  end

  // Register file: preload only in IDLE, index 0 pinned to zero
  always_comb begin
    for (int i = 0; i < REG_CNT; i++) rf_d[i] = rf_q[i];
    if (state_q == S_IDLE && ld_en) rf_d[ld_idx] = ld_data;
    if (state_q == S_WB && wb_en)   rf_d[rd_idx] = exe_res_q;
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q   <= '0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      exe_res_q <= '0;
      exe_ill_q <= 1'b0;
      exe_ovf_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
    end else begin
      instr_q   <= instr_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      exe_res_q <= exe_res_d;
      exe_ill_q <= exe_ill_d;
      exe_ovf_q <= exe_ovf_d;
      done_q    <= done_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < REG_CNT; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_rtype_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_rtype_mc : scoreboard bench for the multi-cycle R-type core       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mips_rtype_mc;

`ifdef MIPS_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        done;
  logic [31:0] result;
  logic        illegal;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;

  logic [33:0] exp_q [$];
  string       nm_q  [$];

  mips_rtype_mc #(.DATA_W(32), .REG_CNT(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .done(done), .result(result), .illegal(illegal), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rt(input int rs, input int rtn, input int rd,
                                     input int sh, input logic [5:0] fn);
    rt = {6'b000000, 5'(rs), 5'(rtn), 5'(rd), 5'(sh), fn};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [33:0] e;
    string n;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected done: got result %h, expected no done", result);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk({n, " result"}, result, e[33:2]);
        chk({n, " illegal"}, {31'b0, illegal}, {31'b0, e[1]});
        chk({n, " ovf"}, {31'b0, ovf}, {31'b0, e[0]});
      end
    end
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 5'(a); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] r, input logic il,
                      input logic ov, input string nm, input logic pre_en,
                      input int pre_a, input logic [31:0] pre_d, input logic poke);
    int lat;
    int w;
    @(negedge clk);
    w = 0;
    while (!instr_ready && w < 10) begin @(negedge clk); w++; end
    instr = ins; instr_valid = 1'b1;
    if (pre_en) begin ld_en = 1'b1; ld_addr = 5'(pre_a); ld_data = pre_d; end
    exp_q.push_back({r, il, ov});
    nm_q.push_back(nm);
    @(posedge clk); #1;
    instr_valid = 1'b0; ld_en = 1'b0;
    if (poke) begin ld_en = 1'b1; ld_addr = 5'd10; ld_data = 32'h99; end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) ld_en = 1'b0;
    end while (!done && lat < 12);
    chk({nm, " latency"}, 32'(lat), 32'd4);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] r, input string nm);
    send(ins, r, 1'b0, 1'b0, nm, 1'b0, 0, 32'h0, 1'b0);
  endtask

  initial begin
    int acc;
    int lat;
    #200000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int lat;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset ready",   {31'b0, instr_ready}, 32'd1);
    chk("reset done",    {31'b0, done},        32'd0);
    chk("reset result",  result,               32'd0);
    chk("reset illegal", {31'b0, illegal},     32'd0);
    chk("reset ovf",     {31'b0, ovf},         32'd0);

    // Basic arithmetic and logic
    preload(1, 32'd5); preload(2, 32'd7);
    issue(32'h00221820,              32'd12,         "add r3");
    issue(rt(3, 1, 4, 0, 6'h22),     32'd7,          "sub r4");
    issue(rt(1, 2, 5, 0, 6'h24),     32'd5,          "and");
    issue(rt(1, 2, 5, 0, 6'h25),     32'd7,          "or");
    issue(rt(1, 2, 5, 0, 6'h26),     32'd2,          "xor");
    issue(rt(1, 2, 5, 0, 6'h21),     32'd12,         "addu");
    issue(rt(1, 2, 6, 0, 6'h23),     32'hFFFFFFFE,   "subu");

    // Preload in the accept cycle is visible; preload while busy is dropped
    send(rt(8, 0, 9, 0, 6'h25), 32'h55, 1'b0, 1'b0, "same-cycle preload", 1'b1, 8, 32'h55, 1'b0);
    send(rt(1, 0, 9, 0, 6'h25), 32'd5,  1'b0, 1'b0, "busy preload instr", 1'b0, 0, 32'h0, 1'b1);
    issue(rt(10, 0, 11, 0, 6'h25),   32'd0,          "busy preload ignored");

    // Signed overflow
    preload(3, 32'd0); preload(1, 32'h7FFFFFFF); preload(2, 32'd1);
    send(rt(1, 2, 3, 0, 6'h20), 32'h80000000, 1'b0, TRAP, "add ovf", 1'b0, 0, 32'h0, 1'b0);
    issue(rt(3, 0, 5, 0, 6'h25),     TRAP ? 32'd0 : 32'h80000000, "r3 after ovf");
    preload(13, 32'h80000000);
    send(rt(13, 2, 12, 0, 6'h22), 32'h7FFFFFFF, 1'b0, TRAP, "sub ovf", 1'b0, 0, 32'h0, 1'b0);

    // Shifts
    preload(1, 32'hF0000000); preload(4, 32'd36); preload(6, 32'd3);
    issue(rt(0, 1, 2, 4, 6'h03),     32'hFF000000,   "sra");
    issue(rt(0, 1, 2, 4, 6'h02),     32'h0F000000,   "srl");
    issue(rt(4, 1, 2, 0, 6'h06),     32'h0F000000,   "srlv 36");
    issue(rt(4, 1, 2, 0, 6'h07),     32'hFF000000,   "srav 36");
    issue(rt(4, 1, 2, 0, 6'h04),     32'h00000000,   "sllv 36");
    issue(rt(0, 6, 7, 31, 6'h00),    32'h80000000,   "sll 31");

    // Compares, nor, r0 immutability
    preload(1, 32'hFFFFFFFF); preload(2, 32'd1);
    issue(rt(1, 2, 3, 0, 6'h2A),     32'd1,          "slt");
    issue(rt(1, 2, 3, 0, 6'h2B),     32'd0,          "sltu");
    issue(rt(0, 0, 3, 0, 6'h27),     32'hFFFFFFFF,   "nor");
    issue(rt(1, 0, 0, 0, 6'h25),     32'hFFFFFFFF,   "or to r0");
    issue(rt(0, 0, 5, 0, 6'h25),     32'd0,          "r0 reads 0");
    preload(0, 32'h1234);
    issue(rt(0, 0, 5, 0, 6'h25),     32'd0,          "r0 preload ignored");

    // Illegal encodings leave the register file untouched
    send({6'b001000, 5'd0, 5'd2, 5'd1, 5'd0, 6'h25}, 32'd0, 1'b1, 1'b0, "bad op", 1'b0, 0, 32'h0, 1'b0);
    send(rt(0, 2, 1, 0, 6'h08), 32'd0, 1'b1, 1'b0, "bad funct", 1'b0, 0, 32'h0, 1'b0);
    issue(rt(1, 0, 5, 0, 6'h25),     32'hFFFFFFFF,   "r1 unchanged");

    // instr_valid held through the whole operation: exactly one accept
    @(negedge clk);
    instr = rt(2, 0, 5, 0, 6'h25); instr_valid = 1'b1;
    exp_q.push_back({32'd1, 1'b0, 1'b0});
    nm_q.push_back("held valid");
    acc = instr_ready ? 1 : 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done && instr_ready) acc++;
    end while (!done && lat < 12);
    instr_valid = 1'b0;
    chk("held valid accepts", 32'(acc), 32'd1);
    chk("held valid latency", 32'(lat), 32'd4);

    // Reset during EXE abandons the instruction
    @(negedge clk);
    instr = rt(1, 2, 3, 0, 6'h20); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid-reset ready",  {31'b0, instr_ready}, 32'd1);
    chk("mid-reset done",   {31'b0, done},        32'd0);
    chk("mid-reset result", result,               32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    issue(rt(3, 0, 5, 0, 6'h25),     32'd0,          "r3 after reset");
    preload(1, 32'd5); preload(2, 32'd7);
    issue(32'h00221820,              32'd12,         "reissued add");
    issue(rt(3, 0, 5, 0, 6'h25),     32'd12,         "r3 written");

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
